tt_vpu_ovi_load_buf: RTL and testbench

- Load-return buffer feeding the vector pipeline's memory response port (rd_data valid/id/data).
- Accepts 512-bit OVI load beats from the CPU, stores up to DEPTH beats and splits each beat into VLEN-bit halves.
- Presents the halves to the pipeline in order, with sequential response IDs.
- Returns one OVI load credit per freed beat slot. Supports flush on kill.

---
 rtl/tt_vpu_ovi_load_buf.sv | 156 +++++++++++++++
 tb/tb_tt_vpu_ovi_load_buf.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_vpu_ovi_load_buf.sv
// rtl/tt_vpu_ovi_load_buf.sv - OVI load-return buffer splitting 2*VLEN beats into VLEN responses
// Optional zero-latency empty-buffer bypass enabled by defining TT_VPU_LDBUF_BYPASS_EN.
module tt_vpu_ovi_load_buf #(
    parameter int VLEN  = 256,
    parameter int DEPTH = 4,
    parameter int ID_W  = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_valid,
    input  logic [2*VLEN-1:0]      load_data,
    input  logic                   load_half_only,
    input  logic [ID_W-1:0]        load_seq_id,
    output logic                   load_credit,
    input  logic                   flush,
    output logic                   rd_data_vld,
    output logic [ID_W-1:0]        rd_data_resp_id,
    output logic [VLEN-1:0]        rd_data,
    input  logic                   rd_data_rtr,
    output logic                   overflow_err,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int PW1 = PW + 1;

    logic [2*VLEN-1:0] mem_data [DEPTH];
    logic [ID_W-1:0]   mem_id   [DEPTH];
    logic [DEPTH-1:0]  mem_half;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          half_sel;
    logic [PW-1:0] occ;
    logic [PW-1:0] pending;
    logic [PW-1:0] pend_next;
    logic [PW1-1:0] pend_sum;
    logic          ovf;

    logic head_vld;
    logic head_half;
    logic full;
    logic head_free;
    logic half_step;
    logic accept;
    logic store;
    logic drop;
    logic credit_inc;
    logic byp_free;
    logic byp_half;

    assign head_vld  = (occ != '0);
    assign head_half = mem_half[rptr];
    assign full      = (occ == PW'(DEPTH));

    // A half-only beat, or the upper half of a full beat, retires the head slot.
    assign head_free = head_vld && rd_data_rtr && !flush && (half_sel || head_half);
    assign half_step = (head_vld && rd_data_rtr && !flush && !half_sel && !head_half) || byp_half;

`ifdef TT_VPU_LDBUF_BYPASS_EN
    logic byp;
    assign byp      = !head_vld && !half_sel && load_valid && !flush;
    assign byp_free = byp && rd_data_rtr && load_half_only;
    assign byp_half = byp && rd_data_rtr && !load_half_only;
`else
    assign byp_free = 1'b0;
    assign byp_half = 1'b0;
`endif

    assign accept     = load_valid && !flush && (!full || head_free);
    assign store      = accept && !byp_free;
    assign drop       = load_valid && !flush && !accept;
    assign credit_inc = head_free || byp_free;

    always_comb begin
        rd_data_vld     = head_vld;
        rd_data         = '0;
        rd_data_resp_id = '0;
        if (head_vld) begin
            if (half_sel) begin
                rd_data         = mem_data[rptr][2*VLEN-1:VLEN];
                rd_data_resp_id = mem_id[rptr] + ID_W'(1);
            end else begin
                rd_data         = mem_data[rptr][VLEN-1:0];
                rd_data_resp_id = mem_id[rptr];
            end
        end
`ifdef TT_VPU_LDBUF_BYPASS_EN
        if (byp) begin
            rd_data_vld     = 1'b1;
            rd_data         = load_data[VLEN-1:0];
            rd_data_resp_id = load_seq_id;
        end
`endif
    end

    // On flush every still-occupied slot is handed back as a credit.
    always_comb begin
        pend_sum = {1'b0, pending} + {{PW{1'b0}}, credit_inc} - {{PW{1'b0}}, load_credit};
        if (flush) begin
            pend_sum = pend_sum + {1'b0, occ};
        end
        if (pend_sum > PW1'(DEPTH)) begin
            pend_next = PW'(DEPTH);
        end else begin
            pend_next = pend_sum[PW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wptr] <= load_data;
            mem_id[wptr]   <= load_seq_id;
            mem_half[wptr] <= load_half_only;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            half_sel <= 1'b0;
            occ      <= '0;
            pending  <= '0;
            ovf      <= 1'b0;
        end else begin
            pending <= pend_next;
            if (drop) begin
                ovf <= 1'b1;
            end
            if (flush) begin
                rptr     <= wptr;
                occ      <= '0;
                half_sel <= 1'b0;
            end else begin
                if (store) begin
                    wptr <= wptr + AW'(1);
                end
                if (head_free) begin
                    rptr <= rptr + AW'(1);
                end
                occ <= occ + PW'(store) - PW'(head_free);
                if (head_free) begin
                    half_sel <= 1'b0;
                end else if (half_step) begin
                    half_sel <= 1'b1;
                end
            end
        end
    end

    assign load_credit  = (pending != '0);
    assign overflow_err = ovf;
    assign occupancy    = occ;

endmodule

// File: tb/tb_tt_vpu_ovi_load_buf.sv
// tb/tb_tt_vpu_ovi_load_buf.sv - directed and randomized checks of tt_vpu_ovi_load_buf
module tb_tt_vpu_ovi_load_buf;
    localparam int VLEN  = 256;
    localparam int DEPTH = 4;
    localparam int ID_W  = 10;

    logic                   clk;
    logic                   reset_n;
    logic                   load_valid;
    logic [2*VLEN-1:0]      load_data;
    logic                   load_half_only;
    logic [ID_W-1:0]        load_seq_id;
    logic                   load_credit;
    logic                   flush;
    logic                   rd_data_vld;
    logic [ID_W-1:0]        rd_data_resp_id;
    logic [VLEN-1:0]        rd_data;
    logic                   rd_data_rtr;
    logic                   overflow_err;
    logic [$clog2(DEPTH):0] occupancy;

    int total = 0;
    int bad = 0;
    int credit_cnt = 0;

    tt_vpu_ovi_load_buf #(.VLEN(VLEN), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_half_only(load_half_only),
        .load_seq_id(load_seq_id),
        .load_credit(load_credit),
        .flush(flush),
        .rd_data_vld(rd_data_vld),
        .rd_data_resp_id(rd_data_resp_id),
        .rd_data(rd_data),
        .rd_data_rtr(rd_data_rtr),
        .overflow_err(overflow_err),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (load_credit === 1'b1) credit_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_valid = 1'b0;
        load_half_only = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        rd_data_rtr = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;
        total++; if (rd_data_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", rd_data_vld); end
        total++; if (load_credit !== 1'b0) begin bad++; $display("FAIL reset_credit got=%b exp=0", load_credit); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
        total++; if (rd_data_resp_id !== 10'd0) begin bad++; $display("FAIL reset_id got=%h exp=0", rd_data_resp_id); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    endtask

    task automatic test_single_full();
        logic [VLEN-1:0] a;
        logic [VLEN-1:0] b;
        int c0;
        a = {8{32'hA5A50001}};
        b = {8{32'h5A5A0002}};
        c0 = credit_cnt;
        rd_data_rtr = 1'b1;
        load_valid = 1'b1;
        load_half_only = 1'b0;
        load_data = {b, a};
        load_seq_id = 10'h3FF;
        cyc();
        idle();
        #1;
        total++; if (rd_data_vld !== 1'b1) begin bad++; $display("FAIL full_lo_vld got=%b exp=1", rd_data_vld); end
        total++; if (rd_data_resp_id !== 10'h3FF) begin bad++; $display("FAIL full_lo_id got=%h exp=3ff", rd_data_resp_id); end
        total++; if (rd_data !== a) begin bad++; $display("FAIL full_lo_data got=%h exp=%h", rd_data, a); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL full_occ got=%0d exp=1", occupancy); end
        cyc();
        total++; if (rd_data_resp_id !== 10'h000) begin bad++; $display("FAIL full_hi_id got=%h exp=000", rd_data_resp_id); end
        total++; if (rd_data !== b) begin bad++; $display("FAIL full_hi_data got=%h exp=%h", rd_data, b); end
        total++; if (load_credit !== 1'b0) begin bad++; $display("FAIL full_early_credit got=%b exp=0", load_credit); end
        cyc();
        total++; if (rd_data_vld !== 1'b0) begin bad++; $display("FAIL full_done_vld got=%b exp=0", rd_data_vld); end
        total++; if (load_credit !== 1'b1) begin bad++; $display("FAIL full_credit got=%b exp=1", load_credit); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_done_occ got=%0d exp=0", occupancy); end
        cyc();
        total++; if (load_credit !== 1'b0) begin bad++; $display("FAIL full_credit_end got=%b exp=0", load_credit); end
        cyc();
        total++; if (credit_cnt - c0 !== 1) begin bad++; $display("FAIL full_credit_cnt got=%0d exp=1", credit_cnt - c0); end
    endtask

    task automatic test_half_only();
        logic [VLEN-1:0] c;
        logic [VLEN-1:0] d;
        logic [VLEN-1:0] e;
        c = {8{32'hC0C00005}};
        d = {8{32'hD0D00007}};
        e = {8{32'hE0E00008}};
        rd_data_rtr = 1'b1;
        load_valid = 1'b1;
        load_half_only = 1'b1;
        load_seq_id = 10'd5;
        load_data = {e, c};
        cyc();
        load_half_only = 1'b0;
        load_seq_id = 10'd7;
        load_data = {e, d};
        #1;
        total++; if (rd_data_resp_id !== 10'd5) begin bad++; $display("FAIL half_id got=%0d exp=5", rd_data_resp_id); end
        total++; if (rd_data !== c) begin bad++; $display("FAIL half_data got=%h exp=%h", rd_data, c); end
        cyc();
        idle();
        #1;
        total++; if (rd_data_resp_id !== 10'd7) begin bad++; $display("FAIL half_next_id got=%0d exp=7", rd_data_resp_id); end
        total++; if (rd_data !== d) begin bad++; $display("FAIL half_next_data got=%h exp=%h", rd_data, d); end
        total++; if (load_credit !== 1'b1) begin bad++; $display("FAIL half_credit got=%b exp=1", load_credit); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL half_occ got=%0d exp=1", occupancy); end
        cyc();
        total++; if (rd_data_resp_id !== 10'd8) begin bad++; $display("FAIL half_up_id got=%0d exp=8", rd_data_resp_id); end
        total++; if (rd_data !== e) begin bad++; $display("FAIL half_up_data got=%h exp=%h", rd_data, e); end
        cyc();
        total++; if (rd_data_vld !== 1'b0) begin bad++; $display("FAIL half_done_vld got=%b exp=0", rd_data_vld); end
        total++; if (load_credit !== 1'b1) begin bad++; $display("FAIL half_done_credit got=%b exp=1", load_credit); end
        cyc();
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        logic [ID_W-1:0] exp_id [8];
        int c0;
        exp_id = '{10'd12, 10'd13, 10'd14, 10'd15, 10'd16, 10'd17, 10'd20, 10'd21};
        c0 = credit_cnt;
        rd_data_rtr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 32'h1000 + 32'(2 * i);
            load_valid = 1'b1;
            load_half_only = 1'b0;
            load_seq_id = ID_W'(10 + 2 * i);
            load_data = {{8{w + 32'd1}}, {8{w}}};
            cyc();
        end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL ovf_fill_occ got=%0d exp=4", occupancy); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow_err); end
        load_seq_id = 10'd18;
        load_data = {16{32'hDEAD0018}};
        cyc();
        idle();
        #1;
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL ovf_occ got=%0d exp=4", occupancy); end
        total++; if (rd_data_resp_id !== 10'd10) begin bad++; $display("FAIL ovf_head got=%0d exp=10", rd_data_resp_id); end
        rd_data_rtr = 1'b1;
        cyc();
        total++; if (rd_data_resp_id !== 10'd11) begin bad++; $display("FAIL ovf_upper got=%0d exp=11", rd_data_resp_id); end
        load_valid = 1'b1;
        load_seq_id = 10'd20;
        load_data = {{8{32'h2001}}, {8{32'h2000}}};
        cyc();
        idle();
        #1;
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL ovf_wwf_occ got=%0d exp=4", occupancy); end
        total++; if (rd_data !== {8{32'h1002}}) begin bad++; $display("FAIL ovf_wwf_data got=%h exp=1002..", rd_data); end
        for (int k = 0; k < 8; k++) begin
            total++; if (rd_data_vld !== 1'b1 || rd_data_resp_id !== exp_id[k]) begin
                bad++; $display("FAIL ovf_drain_%0d vld=%b id=%0d exp_id=%0d", k, rd_data_vld, rd_data_resp_id, exp_id[k]);
            end
            if (k == 6) begin
                total++; if (rd_data !== {8{32'h2000}}) begin bad++; $display("FAIL ovf_sixth_data got=%h exp=2000..", rd_data); end
            end
            cyc();
        end
        total++; if (rd_data_vld !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL ovf_empty vld=%b occ=%0d exp 0/0", rd_data_vld, occupancy); end
        repeat (6) cyc();
        total++; if (credit_cnt - c0 !== 5) begin bad++; $display("FAIL ovf_credit_cnt got=%0d exp=5", credit_cnt - c0); end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
    endtask

    task automatic test_flush();
        int c0;
        rd_data_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_half_only = 1'b0;
            load_seq_id = ID_W'(40 + 2 * i);
            load_data = {16{32'(i + 1)}};
            cyc();
        end
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
        flush = 1'b1;
        load_valid = 1'b1;
        load_seq_id = 10'd50;
        c0 = credit_cnt;
        cyc();
        idle();
        rd_data_rtr = 1'b1;
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", overflow_err); end
        for (int k = 0; k < 5; k++) begin
            total++; if (load_credit !== (k < 3)) begin bad++; $display("FAIL flush_credit_%0d got=%b exp=%b", k, load_credit, (k < 3)); end
            total++; if (rd_data_vld !== 1'b0) begin bad++; $display("FAIL flush_vld_%0d got=%b exp=0", k, rd_data_vld); end
            cyc();
        end
        total++; if (credit_cnt - c0 !== 3) begin bad++; $display("FAIL flush_credit_cnt got=%0d exp=3", credit_cnt - c0); end
    endtask

    task automatic test_random();
        logic [ID_W-1:0] q_id [$];
        logic [VLEN-1:0] q_d [$];
        logic [ID_W-1:0] nid;
        logic [2*VLEN-1:0] d;
        logic ho;
        int sent;
        int credits;
        int ncyc;
        int c0;
        nid = 10'h3F0;
        sent = 0;
        ncyc = 0;
        reset_n = 1'b0;
        idle();
        cyc();
        reset_n = 1'b1;
        credits = DEPTH;
        c0 = credit_cnt;
        while ((sent < 200 || q_id.size() != 0) && ncyc < 5000) begin
            if (load_credit === 1'b1) credits++;
            rd_data_rtr = 1'($urandom_range(0, 1));
            load_valid = 1'b0;
            if (sent < 200 && credits > 0 && $urandom_range(0, 3) != 0) begin
                for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
                ho = ($urandom_range(0, 3) == 0);
                load_valid = 1'b1;
                load_data = d;
                load_half_only = ho;
                load_seq_id = nid;
                q_id.push_back(nid);
                q_d.push_back(d[VLEN-1:0]);
                if (!ho) begin
                    q_id.push_back(nid + ID_W'(1));
                    q_d.push_back(d[2*VLEN-1:VLEN]);
                end
                nid = nid + (ho ? ID_W'(1) : ID_W'(2));
                credits--;
                sent++;
            end
            #1;
            if (rd_data_vld === 1'b1 && rd_data_rtr === 1'b1) begin
                total++;
                if (q_id.size() == 0) begin
                    bad++; $display("FAIL rand_spurious id=%0d exp=none", rd_data_resp_id);
                end else begin
                    if (rd_data_resp_id !== q_id[0] || rd_data !== q_d[0]) begin
                        bad++; $display("FAIL rand_resp id=%0d exp_id=%0d data_ok=%b", rd_data_resp_id, q_id[0], rd_data === q_d[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_d.pop_front());
                end
            end
            cyc();
            ncyc++;
        end
        idle();
        total++; if (ncyc >= 5000) begin bad++; $display("FAIL rand_timeout sent=%0d left=%0d exp done", sent, q_id.size()); end
        repeat (8) cyc();
        total++; if (credit_cnt - c0 !== sent) begin bad++; $display("FAIL rand_credits got=%0d exp=%0d", credit_cnt - c0, sent); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b exp=0", overflow_err); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rand_occ got=%0d exp=0", occupancy); end
    endtask

`ifdef TT_VPU_LDBUF_BYPASS_EN
    task automatic test_bypass();
        logic [VLEN-1:0] f;
        f = {8{32'hB7B70009}};
        rd_data_rtr = 1'b1;
        load_valid = 1'b1;
        load_half_only = 1'b1;
        load_seq_id = 10'd9;
        load_data = {{8{32'h0}}, f};
        #1;
        total++; if (rd_data_vld !== 1'b1) begin bad++; $display("FAIL byp_vld got=%b exp=1", rd_data_vld); end
        total++; if (rd_data !== f) begin bad++; $display("FAIL byp_data got=%h exp=%h", rd_data, f); end
        total++; if (rd_data_resp_id !== 10'd9) begin bad++; $display("FAIL byp_id got=%0d exp=9", rd_data_resp_id); end
        cyc();
        idle();
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL byp_occ got=%0d exp=0", occupancy); end
        total++; if (load_credit !== 1'b1) begin bad++; $display("FAIL byp_credit got=%b exp=1", load_credit); end
        cyc();
        total++; if (load_credit !== 1'b0) begin bad++; $display("FAIL byp_credit_end got=%b exp=0", load_credit); end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        load_half_only = 1'b0;
        load_seq_id = '0;
        flush = 1'b0;
        rd_data_rtr = 1'b0;
        test_reset();
        test_single_full();
        test_half_only();
        test_overflow();
        test_reset();
        test_flush();
        test_random();
`ifdef TT_VPU_LDBUF_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
